pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised fetch-address generator for the sail-core front end, the successor to the fixed 32-bit program counter. It supports configurable XLEN and reset/trap vectors, stall hold, and 2- or 4-byte sequential steps when compressed instructions are enabled. It detects misaligned redirects and applies a timed FENCE.I flush before replaying the fenced PC. It feeds instruction memory directly and takes redirects from the branch/jump address adder and the trap logic.

## Interface
- XLEN, 32, address width
- RESET_VAL, 0, pc_o value in reset
- TRAP_VEC, 'h10, trap/misalignment target
- RVC_EN, 1, compressed instructions enabled (2-byte alignment legal)
- FLUSH_CYCLES, 4, FENCE.I flush length in cycles (1..255)

Ports:
- clk  in  1  CPU clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hold current PC (decode/memory not ready)
- branch_i  in  1  take branch_target_i
- branch_target_i  in  XLEN  redirect address from addr_adder
- trap_i  in  1  external trap request
- fence_i  in  1  FENCE.I seen at current PC
- compressed_i  in  1  instruction at pc_o is 16-bit (ignored if RVC_EN=0)
- pc_o  out  XLEN  registered fetch address
- pc_valid_o  out  1  pc_o is a real fetch request
- fence_busy_o  out  1  flush in progress
- trap_taken_o  out  1  one-cycle pulse: trap redirect committed
- cause_o  out  2  0 none, 1 external trap, 2 misaligned target (valid with trap_taken_o)
- epc_o  out  XLEN  PC at the last trap

## Operation
- States: RUN, FLUSH.
- Next-PC priority: reset > trap_i > branch_i > stall_i > fence_i > sequential.
- trap_i: pc_o <= TRAP_VEC, epc_o <= pc_o, cause 1, trap_taken_o pulse, state RUN.
- branch_i with a misaligned target (target[0]=1, or target[1]=1 when RVC_EN=0): treated as a trap with cause 2. epc_o <= pc_o and pc_o <= TRAP_VEC.
- branch_i with an aligned target: pc_o <= branch_target_i.
- stall_i in RUN: pc_o holds. pc_valid_o stays 1.
- fence_i in RUN (no stall): enter FLUSH and load counter = FLUSH_CYCLES. pc_o holds.
- FLUSH behaviour:
  - pc_valid_o=0 and fence_busy_o=1.
  - Counter decrements every cycle, regardless of stall_i.
  - At counter=1 → RUN next cycle with pc_o unchanged (replay).
- trap_i or branch_i in FLUSH aborts the flush: redirect as above and go to RUN. fence_i in FLUSH is ignored.
- Sequential step is pc_o + 2 if RVC_EN and compressed_i, else pc_o + 4.
- All address arithmetic is modulo 2^XLEN (the maximum address wraps to 0 or 2).
- cause_o holds its last value; it is only meaningful when trap_taken_o=1.

## Timing
- All outputs are registered. A redirect, trap or step takes effect on pc_o the cycle after the input is sampled.
- Reset (sync, high) values: pc_o=RESET_VAL, pc_valid_o=0, fence_busy_o=0, trap_taken_o=0, cause_o=0, epc_o=0, state RUN, counter 0.
- pc_valid_o goes to 1 in the first cycle after reset deasserts.
- Reset asserted mid-FLUSH: the flush is abandoned immediately and the outputs above apply.
- FENCE.I costs exactly FLUSH_CYCLES cycles with pc_valid_o=0, then replays the same pc_o.
- trap_taken_o is high for exactly one cycle per trap.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum (RUN, FLUSH);
  - cause encodings (CAUSE_NONE=0, CAUSE_EXT=1, CAUSE_MISALIGN=2).
- Sub-module pc_flush_timer: 8-bit load/decrement counter with load_i, abort_i, busy_o and done_o.
- The top level contains the next-PC mux and the misalignment check.

## Test plan
- Release reset with RESET_VAL='h100, no inputs for 3 cycles → pc_o 'h100, 'h104, 'h108. pc_valid_o=0 only in the reset cycle.
- RVC_EN=1, compressed_i=1 at pc 'h200, then 0 → pc_o 'h202, then 'h206. XLEN=32 at pc 'hFFFFFFFC, sequential → pc_o wraps to 0.
- stall_i for 2 cycles with branch_i asserted in the second → pc_o holds, then jumps to the target. branch_target_i='h301 → pc_o=TRAP_VEC, epc_o=old pc, cause_o=2, one trap_taken_o pulse.
- fence_i at pc 'h400, FLUSH_CYCLES=4 → pc_valid_o=0 and fence_busy_o=1 for 4 cycles, then pc_o='h400 valid, then 'h404.
- trap_i in cycle 2 of a flush → flush aborted, pc_o=TRAP_VEC, cause_o=1, fence_busy_o=0 next cycle.
- reset asserted mid-flush → next cycle all outputs at reset values. Resumes from RESET_VAL after release.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the pc_sequencer fetch-address generator.
package pc_seq_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_EXT      = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

endpackage

// File: rtl/pc_flush_timer.sv
// 8-bit load/decrement counter that times the FENCE.I flush window.
module pc_flush_timer #(
    parameter logic [7:0] LOAD_VAL = 8'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic abort_i,
    output logic busy_o,
    output logic done_o
);

    logic [7:0] count_q, count_d;

    // Abort wins over load so a redirect in the same cycle never arms a flush.
    always_comb begin
        count_d = count_q;
        if (abort_i) begin
            count_d = 8'd0;
        end else if (load_i) begin
            count_d = LOAD_VAL;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != 8'd0);
    assign done_o = (count_q == 8'd1);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: next-PC mux, misaligned-redirect trap and FENCE.I flush/replay.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VAL    = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'('h10),
    parameter int              RVC_EN       = 1,
    parameter int              FLUSH_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            trap_i,
    input  logic            fence_i,
    input  logic            compressed_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            fence_busy_o,
    output logic            trap_taken_o,
    output logic [1:0]      cause_o,
    output logic [XLEN-1:0] epc_o
);

    localparam logic            RvcOn    = (RVC_EN != 0);
    localparam logic [XLEN-1:0] StepHalf = XLEN'(2);
    localparam logic [XLEN-1:0] StepFull = XLEN'(4);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;
    logic            valid_q, valid_d, trapTaken_q, trapTaken_d;
    logic            misaligned, timerLoad, timerAbort, timerBusy, timerDone;
    logic [XLEN-1:0] stepAddr;

    assign misaligned = branch_target_i[0] | (~RvcOn & branch_target_i[1]);
    assign stepAddr   = pc_q + ((RvcOn && compressed_i) ? StepHalf : StepFull);

    pc_flush_timer #(
        .LOAD_VAL(8'(FLUSH_CYCLES))
    ) u_flush_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timerLoad),
        .abort_i(timerAbort),
        .busy_o (timerBusy),
        .done_o (timerDone)
    );

    // The PC only advances past an address that was actually fetched (valid_q),
    // so the first post-reset cycle issues RESET_VAL before stepping.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        trapTaken_d = 1'b0;
        valid_d     = 1'b1;
        timerLoad   = 1'b0;
        timerAbort  = 1'b0;
        if (trap_i || (branch_i && misaligned)) begin
            pc_d        = TRAP_VEC;
            epc_d       = pc_q;
            cause_d     = trap_i ? CAUSE_EXT : CAUSE_MISALIGN;
            trapTaken_d = 1'b1;
            state_d     = RUN;
            timerAbort  = 1'b1;
        end else if (branch_i) begin
            pc_d       = branch_target_i;
            state_d    = RUN;
            timerAbort = 1'b1;
        end else if (state_q == FLUSH) begin
            if (timerDone) begin
                state_d = RUN;
            end else begin
                valid_d = 1'b0;
            end
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (fence_i && valid_q) begin
            state_d   = FLUSH;
            timerLoad = 1'b1;
            valid_d   = 1'b0;
        end else if (valid_q) begin
            pc_d = stepAddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_VAL;
            epc_q       <= '0;
            cause_q     <= CAUSE_NONE;
            valid_q     <= 1'b0;
            trapTaken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            valid_q     <= valid_d;
            trapTaken_q <= trapTaken_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = valid_q;
    assign fence_busy_o = timerBusy;
    assign trap_taken_o = trapTaken_q;
    assign cause_o      = cause_q;
    assign epc_o        = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a per-cycle reference model and literal checkpoints.
module tb_pc_sequencer;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VAL    = 32'h100;
    localparam logic [31:0] TRAP_VEC     = 32'h10;
    localparam int          RVC_EN       = 1;
    localparam int          FLUSH_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0, branch_i = 1'b0, trap_i = 1'b0;
    logic        fence_i = 1'b0, compressed_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] pc_o, epc_o;
    logic        pc_valid_o, fence_busy_o, trap_taken_o;
    logic [1:0]  cause_o;

    int total = 0;
    int bad = 0;

    pc_sequencer #(
        .XLEN(XLEN), .RESET_VAL(RESET_VAL), .TRAP_VEC(TRAP_VEC),
        .RVC_EN(RVC_EN), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .trap_i(trap_i), .fence_i(fence_i),
        .compressed_i(compressed_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .fence_busy_o(fence_busy_o), .trap_taken_o(trap_taken_o),
        .cause_o(cause_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Reference model: a count of flush cycles still owed replaces any state machine.
    logic [31:0] mPc, mEpc;
    logic [1:0]  mCause;
    logic        mValid, mTrap, started = 1'b0;
    int          mFlushLeft;

    always @(posedge clk) begin : model
        logic [31:0] pc, epc;
        logic [1:0]  cause;
        logic        valid, trap, bad_align;
        int          left;
        pc = mPc; epc = mEpc; cause = mCause; valid = mValid; left = mFlushLeft; trap = 1'b0;
        bad_align = (branch_target_i % 2 == 1) || (RVC_EN == 0 && (branch_target_i % 4) >= 2);
        if (reset) begin
            pc = RESET_VAL; epc = 0; cause = 0; valid = 0; left = 0;
        end else if (trap_i || (branch_i && bad_align)) begin
            epc = pc; pc = TRAP_VEC; cause = trap_i ? 2'd1 : 2'd2;
            trap = 1'b1; valid = 1'b1; left = 0;
        end else if (branch_i) begin
            pc = branch_target_i; valid = 1'b1; left = 0;
        end else if (left > 0) begin
            left = left - 1;
            valid = (left == 0);
        end else if (stall_i) begin
            valid = 1'b1;
        end else if (fence_i && valid) begin
            left = FLUSH_CYCLES; valid = 1'b0;
        end else begin
            if (valid) pc = pc + ((RVC_EN != 0 && compressed_i) ? 32'd2 : 32'd4);
            valid = 1'b1;
        end
        mPc <= pc; mEpc <= epc; mCause <= cause; mValid <= valid;
        mTrap <= trap; mFlushLeft <= left;
        if (reset) started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("model pc_o", pc_o, mPc);
            checkOutput("model pc_valid_o", 32'(pc_valid_o), 32'(mValid));
            checkOutput("model fence_busy_o", 32'(fence_busy_o), 32'(mFlushLeft > 0));
            checkOutput("model trap_taken_o", 32'(trap_taken_o), 32'(mTrap));
            checkOutput("model epc_o", epc_o, mEpc);
            if (mTrap) checkOutput("model cause_o", 32'(cause_o), 32'(mCause));
        end
    end

    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt,
                                 input logic tr, input logic fe, input logic cm);
        stall_i = st; branch_i = br; branch_target_i = tgt;
        trap_i = tr; fence_i = fe; compressed_i = cm;
        @(posedge clk);
        #1;
    endtask

    task automatic expectState(input string tag, input logic [31:0] pc, input logic v,
                               input logic b, input logic t, input logic [1:0] c, input logic [31:0] e);
        checkOutput({tag, " pc_o"}, pc_o, pc);
        checkOutput({tag, " pc_valid_o"}, 32'(pc_valid_o), 32'(v));
        checkOutput({tag, " fence_busy_o"}, 32'(fence_busy_o), 32'(b));
        checkOutput({tag, " trap_taken_o"}, 32'(trap_taken_o), 32'(t));
        checkOutput({tag, " cause_o"}, 32'(cause_o), 32'(c));
        checkOutput({tag, " epc_o"}, epc_o, e);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        expectState("reset", 32'h100, 0, 0, 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("boot0", 32'h100, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("boot1", 32'h104, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("boot2", 32'h108, 1, 0, 0, 0, 0);

        applyStimulus(0, 1, 32'h200, 0, 0, 0); expectState("br200", 32'h200, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1); expectState("rvc2", 32'h202, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("rvc4", 32'h206, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h302, 0, 0, 0); expectState("br302", 32'h302, 1, 0, 0, 0, 0);

        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0); expectState("brtop", 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("wrap", 32'h0, 1, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0); expectState("stall", 32'h0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h500, 0, 0, 0); expectState("stallbr", 32'h500, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h301, 0, 0, 0); expectState("misalign", 32'h10, 1, 0, 1, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("posttrap", 32'h14, 1, 0, 0, 2, 32'h500);

        applyStimulus(0, 1, 32'h400, 0, 0, 0); expectState("br400", 32'h400, 1, 0, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 1, 0); expectState("flush1", 32'h400, 0, 1, 0, 2, 32'h500);
        applyStimulus(1, 0, 0, 0, 0, 0); expectState("flush2", 32'h400, 0, 1, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 1, 0); expectState("flush3", 32'h400, 0, 1, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("flush4", 32'h400, 0, 1, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("replay", 32'h400, 1, 0, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("afterrep", 32'h404, 1, 0, 0, 2, 32'h500);

        applyStimulus(0, 0, 0, 0, 1, 0); expectState("fl2_1", 32'h404, 0, 1, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("fl2_2", 32'h404, 0, 1, 0, 2, 32'h500);
        applyStimulus(0, 0, 0, 1, 0, 0); expectState("flushtrap", 32'h10, 1, 0, 1, 1, 32'h404);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("posttrap2", 32'h14, 1, 0, 0, 1, 32'h404);

        applyStimulus(0, 0, 0, 0, 1, 0); expectState("fl3_1", 32'h14, 0, 1, 0, 1, 32'h404);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("fl3_2", 32'h14, 0, 1, 0, 1, 32'h404);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("midreset", 32'h100, 0, 0, 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("resume0", 32'h100, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0); expectState("resume1", 32'h104, 1, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
